eth_tx_arbiter: RTL and testbench
=================================

# eth_tx_arbiter

Shares the single Ethernet transmit port (48-bit beats, valid/ready) among three frame sources: order engine, market-data echo and status responder. Frames are multi-beat, delimited by a last flag. The arbiter grants one source at a time and holds the grant until that source's last beat transfers. It uses round-robin arbitration with an optional strict-priority override for requester 0, plus a stall watchdog and status counters. It sits between the strategy/response logic and the Ethernet TX interface of the top level.

## Interface
- DATA_W, 48, beat width
- TIMEOUT_CYC, 64, consecutive cycles without source valid mid-frame before the grant is aborted (≥2)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_data  in  3*DATA_W  packed source beats; source i at [i*DATA_W +: DATA_W]
- req_valid  in  3  per-source beat valid
- req_last  in  3  per-source last beat of frame
- req_ready  out  3  per-source ready
- eth_tx_data  out  DATA_W  beat to Ethernet TX
- eth_tx_valid  out  1  beat valid
- eth_tx_last  out  1  last beat of frame
- eth_tx_ready  in  1  Ethernet TX accepts beat
- cfg_prio_en  in  1  1 = source 0 wins every arbitration it requests
- stat_clear  in  1  one-cycle pulse; clears stat_frame_cnt and stat_timeout_err
- stat_grant  out  3  one-hot current grant, 0 when idle
- stat_busy  out  1  1 while in XFER
- stat_frame_cnt  out  16  completed frames, wraps at 65535→0
- stat_timeout_err  out  1  sticky; set on any watchdog abort

## Operation
- FSM states: IDLE, XFER.
- IDLE
  - If any req_valid is set, select a winner and register it into grant.
  - Go to XFER next cycle.
  - Otherwise stay in IDLE.
- Winner selection
  - If cfg_prio_en=1 and req_valid[0]=1: source 0.
  - Otherwise round-robin: search sources rr_ptr+1, rr_ptr+2, rr_ptr (mod 3); first valid wins.
  - rr_ptr is updated to the winner when the grant is registered.
- XFER datapath is combinational from the granted source g:
  - eth_tx_data = req_data[g]
  - eth_tx_valid = req_valid[g]
  - eth_tx_last = req_last[g]
  - req_ready[g] = eth_tx_ready
  - All other req_ready are 0.
- A beat transfers when eth_tx_valid & eth_tx_ready.
  - A transfer with eth_tx_last=1 increments stat_frame_cnt and returns to IDLE.
- Watchdog
  - stall_cnt counts XFER cycles with req_valid[g]=0.
  - It clears on any cycle with req_valid[g]=1, and on entering XFER.
  - When stall_cnt reaches TIMEOUT_CYC-1 while req_valid[g]=0, the arbiter goes to IDLE next cycle and sets stat_timeout_err.
  - The aborted frame is not counted; no last is emitted.
  - Ethernet TX stalling (eth_tx_ready=0) never triggers the watchdog.
- In IDLE, all req_ready, eth_tx_valid and eth_tx_last are 0, and eth_tx_data is 0.
- Changes to cfg_prio_en take effect at the next arbitration only, never mid-frame.

## Timing
- Reset values:
  - state=IDLE, grant=0, rr_ptr=2 (source 0 wins the first round-robin).
  - stall_cnt=0.
  - All req_ready=0, eth_tx_valid=0, eth_tx_last=0, eth_tx_data=0.
  - stat_grant=0, stat_busy=0, stat_frame_cnt=0, stat_timeout_err=0.
- Grant latency: a request valid in IDLE at edge N is granted at N+1. eth_tx_valid can be high from cycle N+1.
- Frame gap: last beat transfers at cycle M → IDLE at M+1 → next grant at M+2. There is at least one idle cycle between frames.
- Single-beat frame (valid+last on the first XFER cycle with ready=1): exactly one XFER cycle.
- Simultaneous last-beat transfer and stat_clear: stat_frame_cnt becomes 1.
- Simultaneous watchdog abort and stat_clear: stat_timeout_err ends at 1.
- rst asserted mid-frame: return to reset values next edge, frame abandoned, no counters updated.
- Requests that drop before being granted are not remembered.
- stat_grant and stat_busy are registered and track state exactly; they are 0 in IDLE.

## Test plan
- Single source: after reset, source 1 sends a 3-beat frame 0x111111111111, 0x222222222222, 0x333333333333 (last on the third), eth_tx_ready=1.
  - Grant one cycle after valid.
  - Eth TX shows the three beats in order, with last on the third.
  - stat_frame_cnt=1, back to IDLE.
- Round-robin: all three sources continuously valid with 1-beat frames.
  - Grant order 0,1,2,0,1,2 with one idle cycle between frames.
  - stat_frame_cnt=6 after six frames.
- Priority: cfg_prio_en=1, sources 0 and 2 always requesting.
  - Source 0 wins every arbitration; source 2 is never granted.
  - After cfg_prio_en=0, the next grant after a source-0 frame goes to 2.
- Backpressure: 2-beat frame from source 0 with eth_tx_ready low for 100 cycles mid-frame.
  - No timeout; beats are held stable.
  - req_ready[0] mirrors eth_tx_ready; the frame completes.
- Watchdog: source 2 sends one beat without last, then drops valid.
  - After 64 stalled cycles: IDLE, stat_timeout_err=1, stat_frame_cnt unchanged.
  - A stat_clear pulse clears the flag.
- Reset mid-frame: assert rst during beat 2 of 4.
  - All outputs are 0 next cycle.
  - The following first request from any source arbitrates with source 0 preferred.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: shares one Ethernet TX beat stream among three frame sources.
// Round-robin with optional source-0 priority, stall watchdog and status counters.
module eth_tx_arbiter #(
  parameter int DATA_W      = 48,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3*DATA_W-1:0]   req_data,
  input  logic [2:0]            req_valid,
  input  logic [2:0]            req_last,
  output logic [2:0]            req_ready,
  output logic [DATA_W-1:0]     eth_tx_data,
  output logic                  eth_tx_valid,
  output logic                  eth_tx_last,
  input  logic                  eth_tx_ready,
  input  logic                  cfg_prio_en,
  input  logic                  stat_clear,
  output logic [2:0]            stat_grant,
  output logic                  stat_busy,
  output logic [15:0]           stat_frame_cnt,
  output logic                  stat_timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic IDLE = 1'b0;
  localparam logic XFER = 1'b1;

  logic             state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       rr_q, rr_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [2:0] win, c1, c2;
  logic       g_valid, done, abort;

  // Winner pick: source 0 override, else search rr+1, rr+2, rr (one-hot rotate)
  always_comb begin
    win = 3'b000;
    c1  = {rr_q[1:0], rr_q[2]};
    c2  = {c1[1:0], c1[2]};
    if (cfg_prio_en && req_valid[0]) begin
      win = 3'b001;
    end else if (|(c1 & req_valid)) begin
      win = c1;
    end else if (|(c2 & req_valid)) begin
      win = c2;
    end else if (|(rr_q & req_valid)) begin
      win = rr_q;
    end
  end

  // Granted-source mux; grant is zero in IDLE so all outputs fall to 0
  always_comb begin
    eth_tx_data  = '0;
    eth_tx_valid = 1'b0;
    eth_tx_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (grant_q[i]) begin
        eth_tx_data  = req_data[i*DATA_W +: DATA_W];
        eth_tx_valid = req_valid[i];
        eth_tx_last  = req_last[i];
      end
    end
    req_ready = grant_q & {3{eth_tx_ready}};
  end

  assign g_valid = |(grant_q & req_valid);
  assign done    = eth_tx_valid & eth_tx_ready & eth_tx_last;
  assign abort   = (state_q == XFER) & ~g_valid & (stall_q == STALL_MAX);

  // Next-state: arbitration, frame completion, watchdog abort, counters
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    stall_d = stall_q;
    cnt_d   = stat_clear ? 16'd0 : cnt_q;
    err_d   = stat_clear ? 1'b0 : err_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = XFER;
          grant_d = win;
          rr_d    = win;
          stall_d = '0;
        end
      end
      XFER: begin
        stall_d = g_valid ? '0 : stall_q + CNT_W'(1);
        if (done) begin
          state_d = IDLE;
          grant_d = 3'b000;
          stall_d = '0;
          cnt_d   = cnt_d + 16'd1;
        end else if (abort) begin
          state_d = IDLE;
          grant_d = 3'b000;
          stall_d = '0;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    endcase
  end

  // State and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      rr_q    <= 3'b100;
      stall_q <= '0;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      stall_q <= stall_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign stat_grant       = grant_q;
  assign stat_busy        = state_q;
  assign stat_frame_cnt   = cnt_q;
  assign stat_timeout_err = err_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: scoreboard bench for eth_tx_arbiter.
// Frame-level reference model predicts grant order; a monitor checks every TX beat.
module tb_eth_tx_arbiter;
  localparam int DW = 48;

  logic            clk = 1'b0;
  logic            rst;
  logic [3*DW-1:0] req_data;
  logic [2:0]      req_valid, req_last, req_ready;
  logic [DW-1:0]   eth_tx_data;
  logic            eth_tx_valid, eth_tx_last, eth_tx_ready;
  logic            cfg_prio_en, stat_clear;
  logic [2:0]      stat_grant;
  logic            stat_busy;
  logic [15:0]     stat_frame_cnt;
  logic            stat_timeout_err;

  always #5 clk = ~clk;

  eth_tx_arbiter #(.DATA_W(DW), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready),
    .eth_tx_data(eth_tx_data), .eth_tx_valid(eth_tx_valid),
    .eth_tx_last(eth_tx_last), .eth_tx_ready(eth_tx_ready),
    .cfg_prio_en(cfg_prio_en), .stat_clear(stat_clear),
    .stat_grant(stat_grant), .stat_busy(stat_busy),
    .stat_frame_cnt(stat_frame_cnt), .stat_timeout_err(stat_timeout_err)
  );

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  beat_t sq[3][$];
  logic  started[3];
  int    gaprun[3];
  bit    gap_en, rand_rdy;
  logic  rdy;
  int    last_w;
  int    checks, errors;
  beat_t e_m;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic add_beat(int s, logic [DW-1:0] d, logic l);
    beat_t b;
    b.src = 2'(s);
    b.d   = d;
    b.l   = l;
    sq[s].push_back(b);
  endtask

  task automatic add_frame(int s, int len);
    for (int k = 0; k < len; k++)
      add_beat(s, {16'($urandom), 32'($urandom)}, (k == len - 1));
  endtask

  // Frame-level model: pick winners from pending frame counts, queue their beats
  task automatic predict();
    int pend[3];
    int mp[3];
    int w, c;
    beat_t b;
    for (int i = 0; i < 3; i++) begin
      pend[i] = 0;
      mp[i]   = 0;
      for (int k = 0; k < sq[i].size(); k++)
        if (sq[i][k].l) pend[i]++;
    end
    while (pend[0] + pend[1] + pend[2] > 0) begin
      w = -1;
      if (cfg_prio_en && pend[0] > 0) w = 0;
      else
        for (int k = 1; k <= 3; k++) begin
          c = (last_w + k) % 3;
          if (w < 0 && pend[c] > 0) w = c;
        end
      do begin
        b = sq[w][mp[w]];
        mp[w]++;
        exp_q.push_back(b);
      end while (!b.l);
      pend[w]--;
      last_w = w;
    end
  endtask

  task automatic drive();
    logic v;
    if (rand_rdy) rdy = ($urandom_range(0, 4) != 0);
    eth_tx_ready = rdy;
    for (int i = 0; i < 3; i++) begin
      if (sq[i].size() == 0) begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end else begin
        v = 1'b1;
        if (gap_en && started[i] && gaprun[i] < 4 &&
            $urandom_range(0, 3) == 0) v = 1'b0;
        gaprun[i] = v ? 0 : gaprun[i] + 1;
        req_valid[i] = v;
        req_last[i]  = sq[i][0].l;
        req_data[i*DW +: DW] = sq[i][0].d;
      end
    end
  endtask

  task automatic step();
    logic [2:0] xf;
    beat_t b;
    drive();
    @(negedge clk);
    xf = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      if (xf[i] && sq[i].size() > 0) begin
        started[i] = !sq[i][0].l;
        b = sq[i].pop_front();
      end
  endtask

  task automatic wait_idle(string name, int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || stat_busy) && n < budget) begin
      step();
      n++;
    end
    chk({name, "_finished"}, 64'(n < budget), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int bad;
    logic [15:0] cnt0;
    beat_t b2;
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
    rdy = 1'b1;
    eth_tx_ready = 1'b1;
    cfg_prio_en = 1'b0;
    stat_clear = 1'b0;
    gap_en = 1'b0;
    rand_rdy = 1'b0;
    last_w = 2;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 3; i++) begin
      started[i] = 1'b0;
      gaprun[i] = 0;
    end

    fork
      forever begin
        @(negedge clk);
        if (!rst && eth_tx_valid && eth_tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_unexpected actual=%0h required=none", eth_tx_data);
          end else begin
            e_m = exp_q.pop_front();
            chk("mon_src", 64'(stat_grant), 64'(3'b001 << e_m.src));
            chk("mon_data", 64'(eth_tx_data), 64'(e_m.d));
            chk("mon_last", 64'(eth_tx_last), 64'(e_m.l));
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 64'(stat_grant), 64'd0);
    chk("rst_busy", 64'(stat_busy), 64'd0);
    chk("rst_cnt", 64'(stat_frame_cnt), 64'd0);
    chk("rst_err", 64'(stat_timeout_err), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_txv", 64'({eth_tx_valid, eth_tx_last}), 64'd0);
    chk("rst_data", 64'(eth_tx_data), 64'd0);
    rst = 1'b0;

    add_beat(1, 48'h111111111111, 1'b0);
    add_beat(1, 48'h222222222222, 1'b0);
    add_beat(1, 48'h333333333333, 1'b1);
    predict();
    step();
    chk("grant_latency", 64'(stat_grant), 64'b010);
    chk("busy_xfer", 64'(stat_busy), 64'd1);
    wait_idle("single", 50);
    chk("single_cnt", 64'(stat_frame_cnt), 64'd1);
    chk("single_idle_grant", 64'(stat_grant), 64'd0);

    add_frame(1, 1);
    predict();
    step();
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    chk("clear_with_last", 64'(stat_frame_cnt), 64'd1);
    chk("single_beat_one_cycle", 64'(stat_busy), 64'd0);

    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    for (int s = 0; s < 3; s++) begin
      add_frame(s, 1);
      add_frame(s, 1);
    end
    predict();
    repeat (12) step();
    chk("rr_cnt", 64'(stat_frame_cnt), 64'd6);
    chk("rr_idle", 64'(stat_busy), 64'd0);
    chk("rr_drained", 64'(exp_q.size()), 64'd0);

    cfg_prio_en = 1'b1;
    for (int k = 0; k < 4; k++) add_frame(0, $urandom_range(1, 2));
    add_frame(2, 1);
    add_frame(2, 2);
    predict();
    wait_idle("prio", 200);
    cfg_prio_en = 1'b0;
    add_frame(0, 1);
    add_frame(0, 1);
    add_frame(2, 1);
    predict();
    wait_idle("prio_off", 200);

    cnt0 = stat_frame_cnt;
    add_frame(0, 2);
    b2 = sq[0][1];
    predict();
    step();
    step();
    rdy = 1'b0;
    bad = 0;
    repeat (100) begin
      step();
      if (!(req_ready == 3'b000 && eth_tx_valid &&
            eth_tx_data == b2.d && eth_tx_last && stat_busy)) bad++;
    end
    chk("bp_hold", 64'(bad), 64'd0);
    rdy = 1'b1;
    eth_tx_ready = 1'b1;
    #1;
    chk("bp_ready_mirror", 64'(req_ready), 64'b001);
    wait_idle("bp", 20);
    chk("bp_no_timeout", 64'(stat_timeout_err), 64'd0);
    chk("bp_cnt", 64'(stat_frame_cnt), 64'(cnt0 + 16'd1));

    cnt0 = stat_frame_cnt;
    add_beat(2, {16'($urandom), 32'($urandom)}, 1'b0);
    exp_q.push_back(sq[2][0]);
    step();
    step();
    repeat (63) step();
    chk("wd_not_early", 64'(stat_busy), 64'd1);
    chk("wd_cnt_same", 64'(stat_frame_cnt), 64'(cnt0));
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    chk("wd_abort_idle", 64'(stat_busy), 64'd0);
    chk("wd_err_with_clear", 64'(stat_timeout_err), 64'd1);
    started[2] = 1'b0;
    last_w = 2;
    step();
    chk("wd_err_kept", 64'(stat_timeout_err), 64'd1);
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    chk("wd_err_cleared", 64'(stat_timeout_err), 64'd0);

    add_frame(1, 1);
    predict();
    wait_idle("pre_rst", 20);
    add_frame(0, 4);
    exp_q.push_back(sq[0][0]);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_txv", 64'({eth_tx_valid, eth_tx_last}), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_data", 64'(eth_tx_data), 64'd0);
    chk("mid_rst_grant", 64'({stat_grant, stat_busy}), 64'd0);
    chk("mid_rst_cnt", 64'(stat_frame_cnt), 64'd0);
    sq[0].delete();
    for (int i = 0; i < 3; i++) started[i] = 1'b0;
    last_w = 2;
    for (int s = 0; s < 3; s++) add_frame(s, 1);
    predict();
    step();
    chk("post_rst_first", 64'(stat_grant), 64'b001);
    wait_idle("post_rst", 50);

    rand_rdy = 1'b1;
    gap_en = 1'b1;
    repeat (30) begin
      cfg_prio_en = 1'($urandom_range(0, 1));
      for (int s = 0; s < 3; s++) begin
        int nf;
        nf = $urandom_range(0, 3);
        for (int k = 0; k < nf; k++) add_frame(s, $urandom_range(1, 5));
      end
      predict();
      wait_idle("rand", 3000);
    end
    rand_rdy = 1'b0;
    gap_en = 1'b0;
    rdy = 1'b1;
    chk("rand_no_timeout", 64'(stat_timeout_err), 64'd0);
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
